// File: rtl/uart_rx_buffer.sv
// Circular receive FIFO between the UART receiver and the host side.
// Registered pop data, fill level, full/empty/threshold flags and a sticky overflow flag.
module uart_rx_buffer #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int OVERWRITE = 0,
    parameter int THRESH    = 192
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_req_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              flush_i,
    input  logic              clr_ovf_i,
    output logic [ADDR_W:0]   count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              thresh_o,
    output logic              overflow_o
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] L_DEPTH  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] L_THRESH = (ADDR_W + 1)'(THRESH);
    localparam bit              L_OVWR   = (OVERWRITE != 0);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_empty;
    logic              r_full;
    logic              r_thresh;
    logic              r_overflow;

    logic              w_pop;
    logic              w_wr;
    logic              w_ovf_evt;
    logic              w_adv_rd;
    logic [ADDR_W:0]   w_count_nxt;

    // A pop while full frees a slot, so the same-cycle write is accepted rather than
    // counted as an overflow.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_pop       = rd_req_i && !r_empty && !flush_i;
        w_ovf_evt   = wr_valid_i && r_full && !w_pop && !flush_i;
        w_wr        = wr_valid_i && !flush_i && (!r_full || w_pop || L_OVWR);
        w_adv_rd    = w_pop || (w_ovf_evt && L_OVWR);
        w_count_nxt = r_count;
        if (flush_i) begin
            w_count_nxt = '0;
        end else if (w_wr && !w_pop && !w_ovf_evt) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_wr) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // NOTE: storage has no reset; only pointers and count define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_thresh   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_empty    <= (w_count_nxt == '0);
            r_full     <= (w_count_nxt == L_DEPTH);
            r_thresh   <= (w_count_nxt >= L_THRESH);
            r_rd_valid <= w_pop;
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_adv_rd) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rd_data_o  = r_rd_data;
    assign rd_valid_o = r_rd_valid;
    assign count_o    = r_count;
    assign empty_o    = r_empty;
    assign full_o     = r_full;
    assign thresh_o   = r_thresh;
    assign overflow_o = r_overflow;

endmodule
